// File: rtl/analog_seq_pkg.sv
// Shared types and constants for the analog sample/compare sequencer.
package analog_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECH,
    ST_GAP1,
    ST_SAMPLE,
    ST_GAP2,
    ST_HOLD,
    ST_LATCH,
    ST_DONE
  } state_e;

  localparam int DEF_PRE_CYC    = 4;
  localparam int DEF_SAMP_CYC   = 8;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int LATCH_CYC      = 3;
  localparam int GAP_CYC        = 1;

  // Cycle count of a phase; IDLE and DONE are open-ended and report 1.
  function automatic int phase_len(state_e s, int pre, int samp, int settle);
    case (s)
      ST_PRECH:  phase_len = pre;
      ST_GAP1:   phase_len = GAP_CYC;
      ST_SAMPLE: phase_len = samp;
      ST_GAP2:   phase_len = GAP_CYC;
      ST_HOLD:   phase_len = settle;
      ST_LATCH:  phase_len = LATCH_CYC;
      default:   phase_len = 1;
    endcase
  endfunction

endpackage

// File: rtl/analog_seq_ctrl_cmp_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into clk.
module cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the async input; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/analog_seq_ctrl.sv
// Phase sequencer for the analog sample/compare macro: non-overlapping
// precharge/sample/hold/latch strobes, 2^AVG_LOG2-decision ones-count,
// result delivered over valid/ready.
module analog_seq_ctrl
  import analog_seq_pkg::*;
#(
  parameter int PRE_CYC    = DEF_PRE_CYC,
  parameter int SAMP_CYC   = DEF_SAMP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int AVG_LOG2   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic                abort,
  input  logic                a_cmp,
  output logic                a_precharge,
  output logic                a_sample,
  output logic                a_hold,
  output logic                a_latch,
  output logic [AVG_LOG2:0]   res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  localparam int MAX_A   = (PRE_CYC > SAMP_CYC) ? PRE_CYC : SAMP_CYC;
  localparam int MAX_B   = (SETTLE_CYC > LATCH_CYC) ? SETTLE_CYC : LATCH_CYC;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int RW      = AVG_LOG2 + 1;
  localparam int NCONV   = 1 << AVG_LOG2;

  state_e          state, state_n;
  logic [CW-1:0]   ph_cnt;
  logic [RW-1:0]   conv_idx;
  logic [RW-1:0]   ones;
  logic [RW-1:0]   sum;
  logic            cmp_s;
  logic            phase_end;
  logic            last_conv;
  logic            hs;
  logic            pre_n, samp_n, hold_n, latch_n, valid_n, busy_n;

  cmp_sync u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_cmp),
    .q   (cmp_s)
  );

  // Next-state selection and decode of the strobes for the upcoming state.
  always_comb begin
    state_n   = state;
    phase_end = (ph_cnt == '0);
    last_conv = (conv_idx == RW'(NCONV - 1));
    hs        = (state == ST_DONE) && res_ready;
    sum       = ones + RW'(cmp_s);
    case (state)
      ST_IDLE:   if (start)     state_n = ST_PRECH;
      ST_PRECH:  if (phase_end) state_n = ST_GAP1;
      ST_GAP1:   if (phase_end) state_n = ST_SAMPLE;
      ST_SAMPLE: if (phase_end) state_n = ST_GAP2;
      ST_GAP2:   if (phase_end) state_n = ST_HOLD;
      ST_HOLD:   if (phase_end) state_n = ST_LATCH;
      ST_LATCH:  if (phase_end) state_n = last_conv ? ST_DONE : ST_PRECH;
      ST_DONE:   if (hs)        state_n = cont ? ST_PRECH : ST_IDLE;
      default:                  state_n = ST_IDLE;
    endcase
    if (abort) state_n = ST_IDLE;
    pre_n   = (state_n == ST_PRECH);
    samp_n  = (state_n == ST_SAMPLE);
    hold_n  = (state_n == ST_HOLD) || (state_n == ST_LATCH);
    latch_n = (state_n == ST_LATCH);
    valid_n = (state_n == ST_DONE);
    busy_n  = (state_n != ST_IDLE);
  end

  // State register plus registered strobes so the macro sees glitch-free edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_precharge <= 1'b0;
      a_sample    <= 1'b0;
      a_hold      <= 1'b0;
      a_latch     <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      a_precharge <= pre_n;
      a_sample    <= samp_n;
      a_hold      <= hold_n;
      a_latch     <= latch_n;
      res_valid   <= valid_n;
      busy        <= busy_n;
    end
  end

  // Shared phase down-counter, reloaded with the phase length on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt <= '0;
    end else if (state_n != state) begin
      ph_cnt <= CW'(phase_len(state_n, PRE_CYC, SAMP_CYC, SETTLE_CYC) - 1);
    end else if (ph_cnt != '0) begin
      ph_cnt <= ph_cnt - 1'b1;
    end
  end

  // Ones-count accumulation and result capture on the final LATCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones     <= '0;
      conv_idx <= '0;
      res_data <= '0;
    end else if (state == ST_IDLE || hs) begin
      ones     <= '0;
      conv_idx <= '0;
    end else if (state == ST_LATCH && phase_end && !abort) begin
      ones <= sum;
      if (last_conv) res_data <= sum;
      else           conv_idx <= conv_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_analog_seq_ctrl.sv
// Directed bench for analog_seq_ctrl at default parameters (T=19, 16 conversions).
module tb_analog_seq_ctrl;

  logic       clk, rst, start, cont, abort, a_cmp, res_ready;
  logic       a_precharge, a_sample, a_hold, a_latch, res_valid, busy;
  logic [4:0] res_data;

  int cyc;
  int checks;
  int errors;

  analog_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .abort       (abort),
    .a_cmp       (a_cmp),
    .a_precharge (a_precharge),
    .a_sample    (a_sample),
    .a_hold      (a_hold),
    .a_latch     (a_latch),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       start;
    bit [4:0] exp; // {pre, samp, hold, latch, busy}
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input bit [4:0] exp);
    chk(name, int'({a_precharge, a_sample, a_hold, a_latch, busy}), int'(exp));
  endtask

  // Advance one cycle and sample just after the edge; also check strobe overlap.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if ((a_precharge && a_sample) || (a_sample && a_hold)) begin
      errors++;
      $display("FAIL overlap (cycle %0d): pre=%0b samp=%0b hold=%0b", cyc, a_precharge, a_sample, a_hold);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int c);
    int conv;
    conv = (c - 1) / 19;
    case (pat)
      1:       pat_bit = 1'b1;
      2:       pat_bit = (conv < 8);
      default: pat_bit = 1'b0;
    endcase
  endfunction

  // Run from the current cycle to cycle 305 (first DONE cycle) with a comparator pattern.
  task automatic drive_conv(input int pat);
    while (cyc < 305) begin
      a_cmp = pat_bit(pat, cyc);
      if (cyc == 304) chk("valid_before_done", int'(res_valid), 0);
      step();
    end
  endtask

  task automatic chk_done(input string name, input int exp_data);
    chk({name, "_valid"}, int'(res_valid), 1);
    chk({name, "_data"}, int'(res_data), exp_data);
    chk_out({name, "_strobes"}, 5'b00001);
  endtask

  task automatic begin_run();
    cyc   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic handshake(input string name, input bit exp_busy);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({name, "_valid_drop"}, int'(res_valid), 0);
    chk({name, "_busy"}, int'(busy), int'(exp_busy));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; a_cmp = 1'b0; res_ready = 1'b0;

    tbl[0]  = '{0,  1'b1, 5'b00000};
    tbl[1]  = '{1,  1'b0, 5'b10001};
    tbl[2]  = '{4,  1'b0, 5'b10001};
    tbl[3]  = '{5,  1'b0, 5'b00001};
    tbl[4]  = '{6,  1'b0, 5'b01001};
    tbl[5]  = '{8,  1'b1, 5'b01001};
    tbl[6]  = '{9,  1'b0, 5'b01001};
    tbl[7]  = '{13, 1'b0, 5'b01001};
    tbl[8]  = '{14, 1'b0, 5'b00001};
    tbl[9]  = '{15, 1'b0, 5'b00101};
    tbl[10] = '{16, 1'b0, 5'b00101};
    tbl[11] = '{17, 1'b0, 5'b00111};
    tbl[12] = '{19, 1'b0, 5'b00111};
    tbl[13] = '{20, 1'b0, 5'b10001};

    // Reset state
    repeat (3) step();
    chk_out("reset_outs", 5'b00000);
    chk("reset_valid", int'(res_valid), 0);
    chk("reset_data", int'(res_data), 0);
    rst = 1'b0;

    // Phase timing table (start at cycle 0, ignored start at cycle 8), all-ones input
    a_cmp = 1'b1;
    cyc = 0;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step();
      start = tbl[i].start;
      chk_out($sformatf("phase_c%0d", tbl[i].cyc), tbl[i].exp);
    end
    start = 1'b0;
    drive_conv(1);
    chk_done("all_ones", 16);
    handshake("all_ones", 1'b0);

    // All-zero input
    begin_run();
    drive_conv(0);
    chk_done("all_zero", 0);
    handshake("all_zero", 1'b0);

    // Backpressure with continuous mode, then second result from a cleared count
    cont = 1'b1;
    begin_run();
    drive_conv(1);
    chk_done("bp_first", 16);
    repeat (10) begin
      step();
      chk_done("bp_hold", 16);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    cont = 1'b0;
    chk_out("cont_restart", 5'b10001);
    chk("cont_valid_drop", int'(res_valid), 0);
    cyc = 1;
    drive_conv(2);
    chk_done("mixed_cont", 8);
    handshake("mixed_cont", 1'b0);

    // Abort at cycle 100; res_data keeps the previous result
    begin_run();
    while (cyc < 100) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("abort_outs", 5'b00000);
    chk("abort_valid", int'(res_valid), 0);
    chk("abort_data_kept", int'(res_data), 8);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_out("start_with_abort", 5'b00000);
    step();
    chk_out("start_with_abort_idle", 5'b00000);

    // Reset mid-operation, then a fresh run
    begin_run();
    while (cyc < 50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("midrst_outs", 5'b00000);
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_data", int'(res_data), 0);
    begin_run();
    chk_out("fresh_prech", 5'b10001);
    drive_conv(2);
    chk_done("fresh_mixed", 8);
    handshake("fresh_mixed", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/analog_seq_ctrl.md
Name: analog_seq_ctrl

Overview:
Digital sequencer for the on-die analog sample/compare macro. It generates non-overlapping precharge, sample, hold and latch phase strobes. It captures the comparator decision at the end of each conversion and accumulates 2^AVG_LOG2 decisions into a ones-count. The result is delivered over a valid/ready handshake to the tile's digital I/O logic, and the block sits between the top-level pin mapping and the analog macro.

Parameters:
- PRE_CYC, 4, precharge phase length in cycles (>=1)
- SAMP_CYC, 8, sample phase length in cycles (>=1)
- SETTLE_CYC, 2, hold-settle length before latch in cycles (>=1)
- AVG_LOG2, 4, log2 of conversions per result (0..8)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a result; sampled only in IDLE
- cont  in  1  continuous mode; restart after each handshake
- abort  in  1  synchronous abort to IDLE
- a_cmp  in  1  comparator output from analog macro (asynchronous)
- a_precharge  out  1  precharge strobe
- a_sample  out  1  sample switch strobe
- a_hold  out  1  hold strobe
- a_latch  out  1  comparator latch strobe
- res_data  out  AVG_LOG2+1  ones-count result
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- busy  out  1  high in any state except IDLE

Behaviour:
- One clock domain; clk and rst as named above. rst is synchronous and active-high.
- Reset: state=IDLE; all strobes 0; res_data=0; res_valid=0; busy=0; synchronizer flops=0; counters=0.
- All outputs are registered Moore outputs, high exactly during their state's cycles.
- States: IDLE, PRECH, GAP1, SAMPLE, GAP2, HOLD, LATCH, DONE.
- IDLE:
  - start=1 -> PRECH next cycle.
  - Clears the ones-count and the conversion index.
- PRECH:
  - Lasts PRE_CYC cycles with a_precharge=1, then GAP1.
- GAP1:
  - Lasts 1 cycle with all strobes 0, then SAMPLE.
- SAMPLE:
  - Lasts SAMP_CYC cycles with a_sample=1, then GAP2.
- GAP2:
  - Lasts 1 cycle with all strobes 0, then HOLD.
- HOLD:
  - Lasts SETTLE_CYC cycles with a_hold=1, then LATCH.
- LATCH:
  - Lasts exactly 3 cycles with a_hold=1 and a_latch=1.
  - On the last LATCH cycle, the 2-flop-synchronized a_cmp is added to the count.
  - If the conversion index is 2^AVG_LOG2-1 -> DONE; otherwise increment the index -> PRECH.
- Strobe invariants:
  - At most one of a_precharge/a_sample is ever high.
  - a_sample and a_hold are never high together.
- Conversion period: T = PRE_CYC+SAMP_CYC+SETTLE_CYC+5 (19 at defaults).
  - With start seen in cycle 0, res_valid rises in cycle 1+T*2^AVG_LOG2 (305 at defaults).
- DONE:
  - res_valid=1 and res_data holds stable until res_valid&&res_ready. The handshake may complete on the first DONE cycle.
  - After the handshake: res_valid=0 next cycle; cont=1 -> PRECH, count cleared; cont=0 -> IDLE.
  - No overrun: the sequence stalls in DONE under backpressure.
- Count width is AVG_LOG2+1 bits. All-ones yields 2^AVG_LOG2 exactly, with no wrap.
- start while not IDLE is ignored. cont is sampled only at the DONE handshake.
- abort in any state: next cycle IDLE, all strobes 0, res_valid=0, busy=0. res_data retains its last value. abort has priority over start and over the handshake.
- rst mid-operation behaves as abort and also clears res_data.

Decomposition:
- Package analog_seq_pkg holds:
  - the state enum;
  - the default phase-length constants;
  - the LATCH_CYC=3 and GAP_CYC=1 constants.
- Sub-module cmp_sync: 2-flop synchronizer with synchronous reset to 0, used for a_cmp.
- A single phase down-counter is shared across states, loaded on each state entry.

Test Plan:
- Phase timing: start at cycle 0 with defaults -> a_precharge high cycles 1-4; all low at 5; a_sample 6-13; all low at 14; a_hold 15-19; a_latch 17-19; next a_precharge at 20.
- All-ones: a_cmp=1 constant, start at cycle 0 -> res_valid=1 at cycle 305, res_data=16; res_ready=1 -> res_valid=0 at 306, busy=0.
- Mixed: a_cmp=1 during conversions 0-7 and 0 during 8-15 (stable across each LATCH window) -> res_data=8; all-zero input -> res_data=0.
- Backpressure/continuous: cont=1 and res_ready=0 for 10 cycles after valid -> res_valid and res_data held, no strobes. Then res_ready=1 -> PRECH the next cycle and a second result 305 cycles later.
- Abort: abort at cycle 100 -> cycle 101 state IDLE, all strobes 0, busy=0, no res_valid. start together with abort in IDLE -> stays IDLE.
- Reset mid-op: rst=1 at cycle 50 for one cycle -> cycle 51 all outputs 0, res_data=0. A subsequent start produces correct timing from a fresh count.
